// File: rtl/mult_ctrl.sv
// Shift-add multiplier control FSM driving ACC Load/Ad/Sh strobes.
// Define MULT_DONE_HOLD_EN to hold Done until St and allow restart from DONE.
module mult_ctrl #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;

  // The shift being issued this cycle is the Nth one.
  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Load      = 1'b0;
    Ad        = 1'b0;
    Sh        = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (St) begin
          Load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ADD;
        end
      end
      ADD: begin
        Busy = 1'b1;
        if (M) begin
          Ad        = 1'b1;
          state_nxt = SHIFT;
        end else begin
          Sh        = 1'b1;
          cnt_nxt   = cnt + CW'(1);
          state_nxt = last ? DONE : ADD;
        end
      end
      SHIFT: begin
        Busy      = 1'b1;
        Sh        = 1'b1;
        cnt_nxt   = cnt + CW'(1);
        state_nxt = last ? DONE : ADD;
      end
      DONE: begin
        Done = 1'b1;
`ifdef MULT_DONE_HOLD_EN
        if (St) begin
          Load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ADD;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences every strobe in the cycle it is asserted.
    if (Rst) begin
      Load = 1'b0;
      Ad   = 1'b0;
      Sh   = 1'b0;
      Busy = 1'b0;
      Done = 1'b0;
    end
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control unit for the shift-add multiplier. It sits directly upstream of the ACC accumulator and drives its Load, Ad and Sh controls.
- It sequences one N-bit unsigned multiply per start request: load operands, then add-and/or-shift once per multiplier bit, then signal completion.
- It reads the multiplier LSB (ACC bit 0, input M) to decide whether each step needs an add before its shift.

Parameters:
- N, 4, operand width in bits (number of shift steps per multiply); legal range 2..16.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- St  input  1  start request; sampled only in IDLE (and in DONE when MULT_DONE_HOLD_EN is defined).
- M  input  1  current multiplier LSB, taken from the ACC register bit 0; stable for the whole cycle.
- Load  output  1  ACC load strobe (operands into ACC).
- Ad  output  1  ACC add strobe (partial product += multiplicand).
- Sh  output  1  ACC right-shift strobe.
- Busy  output  1  high while a multiply is in progress (states ADD and SHIFT).
- Done  output  1  completion indication.

Behaviour:
- States: IDLE, ADD, SHIFT, DONE. Step counter cnt has width clog2(N+1) and counts completed shifts.
- Outputs are decoded combinationally from state, M and St (Mealy) so that ACC samples them on the same edge.
- Load, Ad and Sh are mutually exclusive; at most one is high in any cycle.
- Reset:
  - Rst high forces all outputs to 0 combinationally in that cycle.
  - Next edge: state=IDLE, cnt=0.
  - Reset mid-operation aborts the multiply; no further strobes are issued and ACC contents are don't-care.
- IDLE:
  - Busy=0, Done=0.
  - If St=1: Load=1 and next state is ADD with cnt=0. Otherwise stay in IDLE with all strobes 0.
- ADD (one step decision):
  - If M=1: Ad=1, next state SHIFT.
  - If M=0: Sh=1, cnt+1; next state is DONE if cnt+1==N, else stay in ADD.
- SHIFT:
  - Sh=1, cnt+1; next state is DONE if cnt+1==N, else ADD.
- DONE:
  - Done=1, Busy=0.
  - Without MULT_DONE_HOLD_EN: next state IDLE unconditionally; St in this cycle is ignored.
- Latency:
  - Multiply-phase cycles = N + popcount(multiplier).
  - Done is high in the cycle immediately after the final Sh cycle.
  - From the Load edge, Done rises after N+popcount edges.
- St while Busy=1 is ignored; no restart and no queuing.
- Exactly N Sh pulses per multiply, regardless of operand value, including multiplier=0 or all-ones.
- cnt never exceeds N; it is cleared on every Load.

Optional Feature:
- Macro: MULT_DONE_HOLD_EN.
- Defined:
  - DONE holds Done=1 until St=1 is sampled.
  - St=1 in DONE asserts Load=1 in that same cycle and goes to ADD with cnt=0; this is back-to-back restart with no IDLE cycle.
  - Rst still returns to IDLE.
- Undefined: Done is a single-cycle pulse followed by IDLE, as described in Behaviour.

Test Plan:
- Reset: Rst=1 for 2 edges with St=1 -> Load=Ad=Sh=Busy=Done=0 throughout; IDLE after release with St=0.
- N=4, bench models ACC with multiplier 1011 (M LSB-first 1,1,0,1), St pulse -> strobes Load, Ad, Sh, Ad, Sh, Sh, Ad, Sh, then Done=1 for exactly 1 cycle; 4 Sh, 3 Ad total. ACC product for multiplicand 13 is 143.
- Multiplier 0000 -> Load, then 4 consecutive Sh, no Ad, then Done.
- Multiplier 1111 -> Ad/Sh alternating 4 times (8 cycles), then Done; Busy high for exactly 8 cycles.
- St held high throughout a multiply -> no second Load until IDLE. With MULT_DONE_HOLD_EN: Load in the DONE cycle, immediate second run.
- Rst asserted during the 2nd Sh cycle -> all strobes 0 that cycle; IDLE next edge; a new St gives a clean full sequence.
